// File: rtl/string_mem_search.sv
// rtl/string_mem_search.sv - character buffer with write/read ports, fill mark and first-match search engine
// Scan compares live memory contents; limit is frozen at scan start.
module string_mem_search #(
   parameter int DEPTH  = 64,
   parameter int LENGTH = 8,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [LENGTH-1:0] datain,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] read_addr,
   output logic [LENGTH-1:0] dataout,
   output logic              rd_valid,
   output logic [ADDR_W:0]   used_len,
   input  logic              search_start,
   input  logic [LENGTH-1:0] search_key,
   output logic              search_busy,
   output logic              search_done,
   output logic              search_found,
   output logic [ADDR_W-1:0] search_addr
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

   typedef enum logic {IDLE, SCAN} state_t;

   logic [LENGTH-1:0] mem [DEPTH];
   logic              wr_ok;
   logic              rd_ok;
   logic [ADDR_W:0]   wr_next;
   state_t            state;
   logic [LENGTH-1:0] key;
   logic [ADDR_W:0]   limit;
   logic [ADDR_W-1:0] ptr;

   assign wr_ok   = wr_en && ({1'b0, write_addr} < DEPTH_L);
   assign rd_ok   = {1'b0, read_addr} < DEPTH_L;
   assign wr_next = {1'b0, write_addr} + ONE_L;

   always_ff @(posedge clk) begin
      if (!rst && wr_ok)
         mem[write_addr] <= datain;
   end

   // Same-edge write to the read address forwards the new data.
   always_ff @(posedge clk) begin
      if (rst) begin
         dataout  <= '0;
         rd_valid <= 1'b0;
      end else if (rd_en) begin
         rd_valid <= 1'b1;
         if (!rd_ok)
            dataout <= '0;
         else if (wr_ok && (write_addr == read_addr))
            dataout <= datain;
         else
            dataout <= mem[read_addr];
      end else begin
         rd_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         used_len <= '0;
      else if (wr_ok && (wr_next > used_len))
         used_len <= wr_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         key          <= '0;
         limit        <= '0;
         ptr          <= '0;
         search_busy  <= 1'b0;
         search_done  <= 1'b0;
         search_found <= 1'b0;
         search_addr  <= '0;
      end else begin
         search_done <= 1'b0;
         case (state)
            IDLE: begin
               if (search_start) begin
                  key   <= search_key;
                  limit <= used_len;
                  ptr   <= '0;
                  if (used_len == '0) begin
                     search_done  <= 1'b1;
                     search_found <= 1'b0;
                     search_addr  <= '0;
                  end else begin
                     state       <= SCAN;
                     search_busy <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (mem[ptr] == key) begin
                  search_found <= 1'b1;
                  search_addr  <= ptr;
                  search_done  <= 1'b1;
                  search_busy  <= 1'b0;
                  state        <= IDLE;
               end else if ({1'b0, ptr} == (limit - ONE_L)) begin
                  search_found <= 1'b0;
                  search_addr  <= '0;
                  search_done  <= 1'b1;
                  search_busy  <= 1'b0;
                  state        <= IDLE;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_string_mem_search.sv
// tb/tb_string_mem_search.sv - self-checking bench for string_mem_search
// Read data is scoreboarded through a queue; search results come from a vector table.
module tb_string_mem_search;

   localparam int DEPTH  = 48;
   localparam int LENGTH = 8;
   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [ADDR_W-1:0] write_addr;
   logic [LENGTH-1:0] datain;
   logic              rd_en;
   logic [ADDR_W-1:0] read_addr;
   logic [LENGTH-1:0] dataout;
   logic              rd_valid;
   logic [ADDR_W:0]   used_len;
   logic              search_start;
   logic [LENGTH-1:0] search_key;
   logic              search_busy;
   logic              search_done;
   logic              search_found;
   logic [ADDR_W-1:0] search_addr;

   always #5 clk = ~clk;

   string_mem_search #(.DEPTH(DEPTH), .LENGTH(LENGTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .write_addr(write_addr), .datain(datain),
      .rd_en(rd_en), .read_addr(read_addr), .dataout(dataout), .rd_valid(rd_valid),
      .used_len(used_len), .search_start(search_start), .search_key(search_key),
      .search_busy(search_busy), .search_done(search_done), .search_found(search_found),
      .search_addr(search_addr)
   );

   typedef struct {
      logic [7:0] key;
      logic       found;
      int         addr;
      int         lat;
   } srch_t;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] m_mem [64];
   int         m_used = 0;
   logic [7:0] rd_q [$];
   srch_t      stab [5];
   logic [7:0] fill [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock edge with the currently driven inputs; model updated before the edge.
   task automatic step();
      logic       exp_v;
      logic       was_rst;
      logic [7:0] e;
      exp_v   = 1'b0;
      was_rst = rst;
      if (rst) begin
         m_used = 0;
         rd_q.delete();
      end else begin
         if (rd_en) begin
            exp_v = 1'b1;
            if (int'(read_addr) >= DEPTH) e = 8'd0;
            else if (wr_en && int'(write_addr) < DEPTH && write_addr == read_addr) e = datain;
            else e = m_mem[read_addr];
            rd_q.push_back(e);
         end
         if (wr_en && int'(write_addr) < DEPTH) begin
            m_mem[write_addr] = datain;
            if (int'(write_addr) + 1 > m_used) m_used = int'(write_addr) + 1;
         end
      end
      @(posedge clk);
      #1;
      chk("rd_valid", rd_valid, exp_v);
      if (rd_valid) begin
         e = (rd_q.size() > 0) ? rd_q.pop_front() : 8'bx;
         chk("dataout", dataout, e);
      end
      if (was_rst) chk("dataout_rst", dataout, 0);
      chk("used_len", used_len, m_used);
   endtask

   // Latency is counted in edges after the start edge.
   task automatic wait_done(input int n0, input logic found, input int addr, input int lat, input string name);
      int n;
      n = n0;
      while (!search_done && n < 200) begin
         chk({name, " busy"}, search_busy, 1);
         step();
         n++;
      end
      chk({name, " latency"}, n, lat);
      chk({name, " found"}, search_found, found);
      chk({name, " addr"}, search_addr, addr);
      chk({name, " busy_end"}, search_busy, 0);
      step();
      chk({name, " done_pulse"}, search_done, 0);
      chk({name, " found_hold"}, search_found, found);
   endtask

   task automatic run_search(input logic [7:0] k, input logic found, input int addr, input int lat, input string name);
      search_start = 1'b1;
      search_key   = k;
      step();
      search_start = 1'b0;
      wait_done(0, found, addr, lat, name);
   endtask

   task automatic idle_no_done(input string name);
      int pulses;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (search_done) pulses++;
      end
      chk(name, pulses, 0);
   endtask

   initial begin
      fill = '{8'd2, 8'd3, 8'd4, 8'd8, 8'd23, 8'd10, 8'd11, 8'd12, 8'd24};
      stab[0] = '{8'd23, 1'b1, 4, 5};
      stab[1] = '{8'd99, 1'b0, 0, 9};
      stab[2] = '{8'd24, 1'b1, 8, 9};
      stab[3] = '{8'd2,  1'b1, 0, 1};
      stab[4] = '{8'd12, 1'b1, 7, 8};

      rst = 1'b1; wr_en = 1'b0; write_addr = '0; datain = '0;
      rd_en = 1'b0; read_addr = '0; search_start = 1'b0; search_key = '0;
      step();
      step();
      chk("rst busy", search_busy, 0);
      chk("rst done", search_done, 0);
      chk("rst found", search_found, 0);
      chk("rst addr", search_addr, 0);
      rst = 1'b0;

      // Empty buffer: done is raised directly at the start edge.
      run_search(8'd5, 1'b0, 0, 0, "empty");

      for (int i = 0; i < 9; i++) begin
         wr_en = 1'b1; write_addr = ADDR_W'(i); datain = fill[i];
         step();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 9; i++) begin
         rd_en = 1'b1; read_addr = ADDR_W'(i);
         step();
      end
      rd_en = 1'b0;
      step();
      chk("fill used_len", used_len, 9);

      for (int i = 0; i < 5; i++)
         run_search(stab[i].key, stab[i].found, stab[i].addr, stab[i].lat, $sformatf("srch%0d", i));

      // Start pulse mid-scan must not restart or re-key the scan.
      search_start = 1'b1; search_key = 8'd23;
      step();
      search_start = 1'b0;
      step();
      search_start = 1'b1; search_key = 8'd2;
      step();
      search_start = 1'b0;
      wait_done(2, 1'b1, 4, 5, "ignored_start");
      idle_no_done("ignored_start no second done");

      wr_en = 1'b1; write_addr = 6'd3; datain = 8'd77;
      rd_en = 1'b1; read_addr = 6'd3;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      step();

      search_start = 1'b1; search_key = 8'd99;
      step();
      search_start = 1'b0;
      wr_en = 1'b1; write_addr = 6'd5; datain = 8'd99;
      step();
      wr_en = 1'b0;
      wait_done(1, 1'b1, 5, 6, "midscan_write");

      wr_en = 1'b1; write_addr = 6'd50; datain = 8'd1;
      step();
      wr_en = 1'b0; rd_en = 1'b1; read_addr = 6'd50;
      step();
      rd_en = 1'b0;
      step();

      search_start = 1'b1; search_key = 8'd55;
      step();
      search_start = 1'b0;
      wr_en = 1'b1; write_addr = 6'd20; datain = 8'd55;
      step();
      wr_en = 1'b0;
      wait_done(1, 1'b0, 0, 9, "frozen_limit");
      chk("grown used_len", used_len, 21);

      search_start = 1'b1; search_key = 8'd99;
      step();
      search_start = 1'b0;
      step();
      step();
      rd_en = 1'b1; read_addr = 6'd1;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; rd_en = 1'b0;
      chk("midrst busy", search_busy, 0);
      chk("midrst done", search_done, 0);
      chk("midrst found", search_found, 0);
      chk("midrst used_len", used_len, 0);
      idle_no_done("midrst no done");
      run_search(8'd2, 1'b0, 0, 0, "empty_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
